// File: rtl/uart_fifo_loopback.sv
// uart_fifo_loopback: UART receiver that checks each frame, queues good bytes in a FIFO and echoes them on TX
module uart_fifo_loopback #(
    parameter int CLK_FREQ   = 50000000,
    parameter int UART_BPS   = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst,
    input  logic                          uart_rxd,
    input  logic                          tx_hold,
    output logic                          uart_txd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    frame_err_cnt,
    output logic [7:0]                    parity_err_cnt,
    output logic [7:0]                    ovf_cnt
);
    localparam int BAUD_CNT = CLK_FREQ / UART_BPS;
    localparam int CW = $clog2(BAUD_CNT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [CW-1:0] BAUD_END = CW'(BAUD_CNT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(BAUD_CNT / 2 - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic rx_s1, rx_s2, rx_prev, rx_fall;
    logic [2:0] rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [DATA_BITS-1:0] rx_shr;
    logic rx_par, rx_stop, rx_done;
    logic par_bad, rx_good, push, pop, full, empty;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [2:0] tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [DATA_BITS-1:0] tx_shr;
    logic tx_par, tx_sb, tx_end;

    assign rx_fall = rx_prev & ~rx_s2;
    assign par_bad = (PARITY != 0) && ((^{rx_shr, rx_par}) != (PARITY == 1));
    assign rx_good = rx_done & rx_stop & ~par_bad;
    assign full    = fifo_level == LW'(FIFO_DEPTH);
    assign empty   = fifo_level == '0;
    assign pop     = (tx_state == S_IDLE) & ~empty & ~tx_hold;
    assign push    = rx_good & (~full | pop);
    assign tx_end  = tx_cnt == BAUD_END;

    // Bring the asynchronous RX pin into the clock domain and keep a delayed copy for edge detection
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rxd;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX deserialiser: mid-bit sampling, returns to IDLE right after the stop sample
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shr   <= '0;
            rx_par   <= 1'b0;
            rx_stop  <= 1'b1;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            rx_cnt  <= rx_cnt + 1'b1;
            case (rx_state)
                S_IDLE: begin
                    rx_cnt <= '0;
                    if (rx_fall) rx_state <= S_START;
                end
                S_START: if (rx_cnt == HALF_END) begin
                    rx_cnt   <= '0;
                    rx_bit   <= '0;
                    rx_state <= rx_s2 ? S_IDLE : S_DATA;
                end
                S_DATA: if (rx_cnt == BAUD_END) begin
                    rx_cnt <= '0;
                    rx_shr <= {rx_s2, rx_shr[DATA_BITS-1:1]};
                    rx_bit <= rx_bit + 1'b1;
                    if (rx_bit == LAST_BIT) rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: if (rx_cnt == BAUD_END) begin
                    rx_cnt   <= '0;
                    rx_par   <= rx_s2;
                    rx_state <= S_STOP;
                end
                S_STOP: if (rx_cnt == BAUD_END) begin
                    rx_stop  <= rx_s2;
                    rx_done  <= 1'b1;
                    rx_state <= S_IDLE;
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

    // Error and overflow counters, saturating at 255; a framing error masks any parity error
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            frame_err_cnt  <= '0;
            parity_err_cnt <= '0;
            ovf_cnt        <= '0;
        end else begin
            if (rx_done && !rx_stop && frame_err_cnt != 8'hFF) frame_err_cnt <= frame_err_cnt + 1'b1;
            if (rx_done && rx_stop && par_bad && parity_err_cnt != 8'hFF) parity_err_cnt <= parity_err_cnt + 1'b1;
            if (rx_good && full && !pop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge sys_clk) begin
        if (push) mem[wptr] <= rx_shr;
    end

    // FIFO pointers and occupancy; a pop on a full FIFO frees the slot a same-cycle push uses
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            fifo_level <= fifo_level + LW'(push) - LW'(pop);
        end
    end

    // TX serialiser: pops in IDLE and walks start, data, parity and stop bits of BAUD_CNT cycles each
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shr   <= '0;
            tx_par   <= 1'b0;
            tx_sb    <= 1'b0;
        end else begin
            tx_cnt <= tx_end ? '0 : tx_cnt + 1'b1;
            case (tx_state)
                S_IDLE: begin
                    tx_cnt <= '0;
                    if (pop) begin
                        tx_shr   <= mem[rptr];
                        tx_par   <= (^mem[rptr]) ^ (PARITY == 1);
                        tx_bit   <= '0;
                        tx_sb    <= 1'b0;
                        tx_state <= S_START;
                    end
                end
                S_START: if (tx_end) tx_state <= S_DATA;
                S_DATA: if (tx_end) begin
                    tx_shr <= tx_shr >> 1;
                    tx_bit <= tx_bit + 1'b1;
                    if (tx_bit == LAST_BIT) tx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: if (tx_end) tx_state <= S_STOP;
                S_STOP: if (tx_end) begin
                    tx_sb <= 1'b1;
                    if (tx_sb == 1'(STOP_BITS - 1)) tx_state <= S_IDLE;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // Registered line driver, one cycle behind the TX state so the start bit follows the pop by a cycle
    always_ff @(posedge sys_clk) begin
        if (sys_rst) uart_txd <= 1'b1;
        else uart_txd <= (tx_state == S_START) ? 1'b0 :
                         (tx_state == S_DATA) ? tx_shr[0] :
                         (tx_state == S_PARITY) ? tx_par : 1'b1;
    end
endmodule

// File: tb/tb_uart_fifo_loopback.sv
// tb_uart_fifo_loopback: three loopback instances (8N1 default baud, 8N1 fast, 7E1 fast) with a per-instance echo scoreboard
module tb_uart_fifo_loopback;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst [3];
    logic rxd [3];
    logic hold [3];
    logic txd [3];
    logic ignore [3];
    logic [4:0] lvl [3];
    logic [7:0] fe [3];
    logic [7:0] pe [3];
    logic [7:0] ov [3];
    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];
    logic [7:0] sb2 [$];
    int tests = 0;
    int fails = 0;

    uart_fifo_loopback u0 (
        .sys_clk(clk), .sys_rst(rst[0]), .uart_rxd(rxd[0]), .tx_hold(hold[0]), .uart_txd(txd[0]),
        .fifo_level(lvl[0]), .frame_err_cnt(fe[0]), .parity_err_cnt(pe[0]), .ovf_cnt(ov[0])
    );
    uart_fifo_loopback #(.UART_BPS(2500000)) u1 (
        .sys_clk(clk), .sys_rst(rst[1]), .uart_rxd(rxd[1]), .tx_hold(hold[1]), .uart_txd(txd[1]),
        .fifo_level(lvl[1]), .frame_err_cnt(fe[1]), .parity_err_cnt(pe[1]), .ovf_cnt(ov[1])
    );
    uart_fifo_loopback #(.UART_BPS(2500000), .DATA_BITS(7), .PARITY(2)) u2 (
        .sys_clk(clk), .sys_rst(rst[2]), .uart_rxd(rxd[2]), .tx_hold(hold[2]), .uart_txd(txd[2]),
        .fifo_level(lvl[2]), .frame_err_cnt(fe[2]), .parity_err_cnt(pe[2]), .ovf_cnt(ov[2])
    );

    function automatic int bcnt(int k);
        return (k == 0) ? 50000000 / 115200 : 50000000 / 2500000;
    endfunction

    function automatic void sb_push(int k, logic [7:0] d);
        if (k == 0) sb0.push_back(d);
        else if (k == 1) sb1.push_back(d);
        else sb2.push_back(d);
    endfunction

    function automatic int sb_size(int k);
        return (k == 0) ? sb0.size() : (k == 1) ? sb1.size() : sb2.size();
    endfunction

    function automatic logic [7:0] sb_pop(int k);
        if (k == 0) return sb0.pop_front();
        if (k == 1) return sb1.pop_front();
        return sb2.pop_front();
    endfunction

    // Drive one serial frame LSB first; parity bit and stop value given explicitly
    task automatic send_frame(int k, logic [7:0] d, logic has_par, logic pbit, logic stop);
        int b = bcnt(k);
        int db = (k == 2) ? 7 : 8;
        @(negedge clk);
        rxd[k] = 1'b0;
        repeat (b) @(negedge clk);
        for (int i = 0; i < db; i++) begin
            rxd[k] = d[i];
            repeat (b) @(negedge clk);
        end
        if (has_par) begin
            rxd[k] = pbit;
            repeat (b) @(negedge clk);
        end
        rxd[k] = stop;
        repeat (b) @(negedge clk);
        rxd[k] = 1'b1;
    endtask

    // Decode TX frames at mid-bit and compare against the scoreboard head
    task automatic monitor(int k);
        int b = bcnt(k);
        int db = (k == 2) ? 7 : 8;
        logic [7:0] d, e;
        logic st, p, sp;
        forever begin
            @(negedge clk);
            if (txd[k] === 1'b0) begin
                repeat (b / 2) @(negedge clk);
                st = txd[k];
                d = '0;
                for (int i = 0; i < db; i++) begin
                    repeat (b) @(negedge clk);
                    d[i] = txd[k];
                end
                p = 1'b0;
                if (k == 2) begin
                    repeat (b) @(negedge clk);
                    p = txd[k];
                end
                repeat (b) @(negedge clk);
                sp = txd[k];
                if (!ignore[k]) begin
                    tests++;
                    if (sb_size(k) == 0) begin
                        fails++;
                        $display("FAIL echo%0d: got unexpected byte %h, expected none", k, d);
                    end else begin
                        e = sb_pop(k);
                        if (st !== 1'b0 || sp !== 1'b1 || d !== e || (k == 2 && p !== ^e[6:0])) begin
                            fails++;
                            $display("FAIL echo%0d: got start=%b data=%h par=%b stop=%b, expected start=0 data=%h par=%b stop=1",
                                     k, st, d, p, sp, e, (k == 2) ? ^e[6:0] : 1'b0);
                        end
                    end
                end
            end
        end
    endtask

    task automatic drain(int k, int limit);
        int n = 0;
        while ((sb_size(k) != 0 || lvl[k] != 0 || txd[k] !== 1'b1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        repeat (bcnt(k)) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) rst[k] = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (txd[k] !== 1'b1 || lvl[k] !== 5'd0 || fe[k] !== 8'd0 || pe[k] !== 8'd0 || ov[k] !== 8'd0) begin
                fails++;
                $display("FAIL reset%0d: got txd=%b lvl=%0d fe=%0d pe=%0d ov=%0d, expected 1 0 0 0 0",
                         k, txd[k], lvl[k], fe[k], pe[k], ov[k]);
            end
        end
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_echo();
        int n;
        sb_push(0, 8'hA5);
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                n = 0;
                while (lvl[0] !== 5'd1 && n < 20000) begin
                    @(negedge clk);
                    n++;
                end
                n = 0;
                while (txd[0] !== 1'b0 && n < 10) begin
                    @(negedge clk);
                    n++;
                end
                tests++;
                if (n !== 2) begin
                    fails++;
                    $display("FAIL echo_latency: got %0d cycles from write to start edge, expected 2", n);
                end
            end
        join
        drain(0, 10000);
        tests++;
        if (sb_size(0) != 0 || fe[0] !== 8'd0 || pe[0] !== 8'd0 || ov[0] !== 8'd0 || lvl[0] !== 5'd0) begin
            fails++;
            $display("FAIL echo_state: got pending=%0d fe=%0d pe=%0d ov=%0d lvl=%0d, expected all 0",
                     sb_size(0), fe[0], pe[0], ov[0], lvl[0]);
        end
    endtask

    task automatic test_glitch();
        int lows = 0;
        rxd[0] = 1'b0;
        repeat (100) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (1500) begin
            @(negedge clk);
            if (txd[0] !== 1'b1) lows++;
        end
        tests++;
        if (lows != 0) begin
            fails++;
            $display("FAIL glitch_txd: got %0d non-idle cycles, expected 0", lows);
        end
        tests++;
        if (fe[0] !== 8'd0 || pe[0] !== 8'd0 || ov[0] !== 8'd0 || lvl[0] !== 5'd0) begin
            fails++;
            $display("FAIL glitch_cnt: got fe=%0d pe=%0d ov=%0d lvl=%0d, expected 0 0 0 0", fe[0], pe[0], ov[0], lvl[0]);
        end
    endtask

    task automatic test_burst();
        hold[1] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i < 16) sb_push(1, 8'(i));
            send_frame(1, 8'(i), 1'b0, 1'b0, 1'b1);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (lvl[1] !== 5'd16) begin
            fails++;
            $display("FAIL burst_level: got %0d, expected 16", lvl[1]);
        end
        tests++;
        if (ov[1] !== 8'd4) begin
            fails++;
            $display("FAIL burst_ovf: got %0d, expected 4", ov[1]);
        end
        tests++;
        if (txd[1] !== 1'b1 || sb_size(1) != 16) begin
            fails++;
            $display("FAIL burst_hold: got txd=%b pending=%0d, expected txd=1 pending=16", txd[1], sb_size(1));
        end
        hold[1] = 1'b0;
        drain(1, 6000);
        tests++;
        if (lvl[1] !== 5'd0 || sb_size(1) != 0) begin
            fails++;
            $display("FAIL burst_drain: got lvl=%0d pending=%0d, expected 0 0", lvl[1], sb_size(1));
        end
    endtask

    task automatic test_parity();
        sb_push(2, 8'h41);
        send_frame(2, 8'h41, 1'b1, 1'b0, 1'b1);
        send_frame(2, 8'h41, 1'b1, 1'b1, 1'b1);
        drain(2, 2000);
        tests++;
        if (pe[2] !== 8'd1 || fe[2] !== 8'd0 || ov[2] !== 8'd0) begin
            fails++;
            $display("FAIL parity_cnt: got pe=%0d fe=%0d ov=%0d, expected 1 0 0", pe[2], fe[2], ov[2]);
        end
        tests++;
        if (sb_size(2) != 0 || lvl[2] !== 5'd0) begin
            fails++;
            $display("FAIL parity_echo: got pending=%0d lvl=%0d, expected 0 0", sb_size(2), lvl[2]);
        end
    endtask

    task automatic test_frame_err();
        send_frame(1, 8'h3C, 1'b0, 1'b0, 1'b0);
        repeat (bcnt(1)) @(negedge clk);
        sb_push(1, 8'h55);
        send_frame(1, 8'h55, 1'b0, 1'b0, 1'b1);
        drain(1, 2000);
        tests++;
        if (fe[1] !== 8'd1 || pe[1] !== 8'd0) begin
            fails++;
            $display("FAIL frame_cnt: got fe=%0d pe=%0d, expected 1 0", fe[1], pe[1]);
        end
        tests++;
        if (sb_size(1) != 0 || lvl[1] !== 5'd0) begin
            fails++;
            $display("FAIL frame_echo: got pending=%0d lvl=%0d, expected 0 0", sb_size(1), lvl[1]);
        end
    endtask

    task automatic test_reset_mid_tx();
        int n = 0;
        int lows = 0;
        hold[1] = 1'b1;
        send_frame(1, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_frame(1, 8'h01, 1'b0, 1'b0, 1'b1);
        send_frame(1, 8'h02, 1'b0, 1'b0, 1'b1);
        send_frame(1, 8'h03, 1'b0, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        tests++;
        if (lvl[1] !== 5'd4) begin
            fails++;
            $display("FAIL rst_queue: got lvl=%0d, expected 4", lvl[1]);
        end
        ignore[1] = 1'b1;
        hold[1] = 1'b0;
        while (txd[1] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5 * bcnt(1) + 5) @(negedge clk);
        rst[1] = 1'b1;
        @(negedge clk);
        tests++;
        if (txd[1] !== 1'b1 || lvl[1] !== 5'd0) begin
            fails++;
            $display("FAIL rst_mid: got txd=%b lvl=%0d, expected 1 0", txd[1], lvl[1]);
        end
        tests++;
        if (fe[1] !== 8'd0 || ov[1] !== 8'd0) begin
            fails++;
            $display("FAIL rst_cnt: got fe=%0d ov=%0d, expected 0 0", fe[1], ov[1]);
        end
        rst[1] = 1'b0;
        repeat (600) begin
            @(negedge clk);
            if (txd[1] !== 1'b1 || lvl[1] !== 5'd0) lows++;
        end
        tests++;
        if (lows != 0) begin
            fails++;
            $display("FAIL rst_quiet: got %0d active cycles after reset, expected 0", lows);
        end
        ignore[1] = 1'b0;
        sb_push(1, 8'h5A);
        send_frame(1, 8'h5A, 1'b0, 1'b0, 1'b1);
        drain(1, 2000);
        tests++;
        if (sb_size(1) != 0) begin
            fails++;
            $display("FAIL rst_resume: got %0d pending echoes, expected 0", sb_size(1));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            rxd[k] = 1'b1;
            hold[k] = 1'b0;
            ignore[k] = 1'b0;
        end
        fork
            monitor(0);
            monitor(1);
            monitor(2);
        join_none
        test_reset();
        test_echo();
        test_glitch();
        test_burst();
        test_parity();
        test_frame_err();
        test_reset_mid_tx();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (sb_size(k) != 0) begin
                fails++;
                $display("FAIL final%0d: got %0d unechoed bytes, expected 0", k, sb_size(k));
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_fifo_loopback.md
Name: uart_fifo_loopback

Overview:
- Parametrised successor to the plain UART echo.
- Receives serial frames and checks framing and parity. Good bytes go into an internal FIFO; bad frames are discarded and counted.
- Retransmits FIFO contents on the TX line, with a hold input for flow control.
- Self-contained: RX deserialiser, synchronous FIFO and TX serialiser are implemented inline. Sits directly between the board UART pins and nothing else (echo/bring-up block).

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate. Bit period BAUD_CNT = CLK_FREQ/UART_BPS (integer truncation); mid-bit point = BAUD_CNT/2.
- DATA_BITS, 8, data bits per frame. Legal range 5..8; sent and received LSB first.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits, 1 or 2. TX sends this many. RX checks only the first.
- FIFO_DEPTH, 16, FIFO entries. Must be a power of 2, at least 2.

Ports:
- sys_clk  in  1  system clock; all logic on the rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- uart_rxd  in  1  serial input, asynchronous to sys_clk.
- tx_hold  in  1  when high, TX starts no new frame; a frame already in progress completes.
- uart_txd  out  1  serial output, idle high.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err_cnt  out  8  count of frames with bad stop bit; saturates at 255.
- parity_err_cnt  out  8  count of frames with parity mismatch; saturates at 255.
- ovf_cnt  out  8  count of good bytes dropped because the FIFO was full; saturates at 255.

Behaviour:
- Reset values (sys_rst high at a clock edge): uart_txd=1; fifo_level=0; all counters 0; RX and TX FSMs to IDLE; FIFO pointers to 0.
- Reset asserted mid-frame aborts that frame without counting it. uart_txd returns high on the next edge.
- RX input: uart_rxd passes through a 2-flop synchroniser, reset to 1. Falling-edge detect on the synchronised signal.
- RX FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on a falling edge.
  - START: at BAUD_CNT/2, if the line is high, treat as a glitch and go to IDLE with no counts. Otherwise go to DATA.
  - DATA: sample every BAUD_CNT cycles at mid-bit, DATA_BITS samples.
  - PARITY: present only if PARITY != 0; sample one bit.
  - STOP: sample at mid-bit.
- Frame end (cycle after the stop sample):
  - Stop sample 0: frame_err_cnt++ and byte discarded. Parity is not counted for that frame.
  - Otherwise, parity mismatch: parity_err_cnt++ and byte discarded.
  - Otherwise the byte is good. It is written into the FIFO if not full; if full, ovf_cnt++ and the byte is discarded.
- RX re-arm: RX returns to IDLE right after the stop sample, so a start edge half a bit later is caught.
- Parity definition: odd means data bits plus parity bit contain an odd number of 1s; even means an even number.
- FIFO: width DATA_BITS.
  - Write and read on the same cycle are both allowed, including when full (read frees the slot the write uses) and when empty (write only; the read is suppressed because the FIFO is empty).
  - fifo_level updates on the cycle after the push/pop.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - In IDLE, if the FIFO is not empty and tx_hold is low, pop one entry and go to START on the same edge.
  - uart_txd goes low the cycle after the pop.
  - Each bit is held exactly BAUD_CNT cycles.
  - Sequence: start(0), data LSB first, parity bit (if enabled), then STOP_BITS stop bits of 1.
  - After the last stop bit, back to IDLE; a new frame may start on the next cycle.
- End-to-end latency: for a good byte with the FIFO empty and TX idle, the write happens at cycle N. Pop happens at N+1 and uart_txd falls at N+2.
- Counters: increment by 1 per event and hold at 255.

Test Plan:
- 8N1 echo, defaults (BAUD_CNT=434): send 0xA5 -> uart_txd frame 0,1,0,1,0,0,1,0,1,1 at 434 cycles/bit. TX start edge exactly 2 cycles after the FIFO write. All counters 0.
- Burst with FIFO_DEPTH=16, tx_hold=1: send 20 bytes 0x00..0x13 -> fifo_level=16, ovf_cnt=4, uart_txd stays 1. Release tx_hold -> exactly 0x00..0x0F echoed in order, fifo_level ends at 0.
- PARITY=2, DATA_BITS=7: send 0x41 with parity bit 0 (good) then 0x41 with parity bit 1 (bad) -> one echo of 0x41 with parity bit 0; parity_err_cnt=1.
- Stop bit driven 0 on byte 0x3C -> no echo, frame_err_cnt=1. The next valid byte 0x55, starting one bit later, is echoed correctly.
- Glitch: uart_rxd low for 100 cycles (less than 217) -> no frame, no counter change, uart_txd stays 1.
- Reset mid-TX, after bit 3 of 0xFF with 3 more bytes queued -> uart_txd=1 and fifo_level=0 on the next cycle. No further output until new RX input arrives.
